// File: rtl/modinv_engine.sv
// modinv_engine: binary extended-Euclid engine producing a^-1 mod p (mode 0)
// or b*a^-1 mod p (mode 1) for an odd modulus p. The engine does one
// algorithm step per clock, has valid/ready handshakes on both sides, and
// flags invalid or non-invertible operands through out_err.
module modinv_engine #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_err,
  output logic [CNT_W-1:0] out_cycles,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  // x/2 mod p for odd p: an odd x gets p added first, on WIDTH+1 bits so the
  // sum cannot overflow before the shift.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, p} : {(WIDTH+1){1'b0}});
    return WIDTH'(s >> 1);
  endfunction

  // (a - b) mod p for a, b in [0, p-1]: a borrow out of the WIDTH+1-bit
  // difference means the result went negative, so p is added back.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + {1'b0, p};
    return d[WIDTH-1:0];
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_v;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_x2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_err;
  logic [CNT_W-1:0] r_out_cycles;

  logic             w_bad;
  logic [WIDTH-1:0] w_x1_init;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_u_nxt;
  logic [WIDTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_x1_nxt;
  logic [WIDTH-1:0] w_x2_nxt;
  logic             w_fin;
  logic             w_fin_err;
  logic [WIDTH-1:0] w_fin_r;

  // Request validation and initial numerator, evaluated in the accept cycle.
  assign w_bad = ~in_p[0] | (in_p < THREE) | (in_a == '0) | (in_a >= in_p) |
                 (in_mode & (in_b >= in_p));
  assign w_x1_init = in_mode ? in_b : ONE;

  // Step counter saturates at all-ones instead of wrapping.
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // One extended-Euclid step; the branches are in strict priority order.
  always_comb begin
    w_u_nxt   = r_u;
    w_v_nxt   = r_v;
    w_x1_nxt  = r_x1;
    w_x2_nxt  = r_x2;
    w_fin     = 1'b0;
    w_fin_err = 1'b0;
    w_fin_r   = '0;
    if (r_u == ONE) begin
      w_fin   = 1'b1;
      w_fin_r = r_x1;
    end else if (r_v == ONE) begin
      w_fin   = 1'b1;
      w_fin_r = r_x2;
    end else if ((r_u == '0) || (r_v == '0)) begin
      // gcd(a, p) > 1: one side collapsed to zero without reaching one.
      w_fin     = 1'b1;
      w_fin_err = 1'b1;
    end else if (!r_u[0]) begin
      w_u_nxt  = r_u >> 1;
      w_x1_nxt = half_mod(r_x1, r_p);
    end else if (!r_v[0]) begin
      w_v_nxt  = r_v >> 1;
      w_x2_nxt = half_mod(r_x2, r_p);
    end else if (r_u >= r_v) begin
      w_u_nxt  = r_u - r_v;
      w_x1_nxt = sub_mod(r_x1, r_x2, r_p);
    end else begin
      w_v_nxt  = r_v - r_u;
      w_x2_nxt = sub_mod(r_x2, r_x1, r_p);
    end
  end

  // Control FSM with registered handshake/status outputs and working state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_p          <= '0;
      r_u          <= '0;
      r_v          <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_r      <= '0;
      r_out_err    <= 1'b0;
      r_out_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_p        <= in_p;
            r_u        <= in_a;
            r_v        <= in_p;
            r_x1       <= w_x1_init;
            r_x2       <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_bad) begin
              // Rejected operands skip RUN entirely and report zero cycles.
              r_out_r      <= '0;
              r_out_err    <= 1'b1;
              r_out_cycles <= '0;
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          r_u   <= w_u_nxt;
          r_v   <= w_v_nxt;
          r_x1  <= w_x1_nxt;
          r_x2  <= w_x2_nxt;
          if (w_fin) begin
            // The terminating cycle is counted too.
            r_out_r      <= w_fin_r;
            r_out_err    <= w_fin_err;
            r_out_cycles <= w_cnt_nxt;
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign out_r      = r_out_r;
  assign out_err    = r_out_err;
  assign out_cycles = r_out_cycles;

endmodule

// File: tb/tb_modinv_engine.sv
// tb_modinv_engine: scoreboard bench for modinv_engine at WIDTH = 256.
// The driver pushes the expected response for every accepted request; an
// independent monitor pops and compares whenever the engine presents a result.
module tb_modinv_engine;
  localparam int W  = 256;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W-1:0]  in_p;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_r;
  logic          out_err;
  logic [CW-1:0] out_cycles;
  logic          busy;

  modinv_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_err(out_err), .out_cycles(out_cycles), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         err;
    int           cyc_exp;   // -1: only bounded by 4*W
    logic         prod_chk;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [W-1:0] P25519;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] modmul(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    t = t % {{W{1'b0}}, m};
    return W'(t);
  endfunction

  function automatic logic [W-1:0] modpow(input logic [W-1:0] base, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [W-1:0] acc;
    acc = W'(1);
    for (int i = W - 1; i >= 0; i--) begin
      acc = modmul(acc, acc, m);
      if (e[i]) acc = modmul(acc, base, m);
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], $urandom()};
    return r;
  endfunction

  task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input logic [W-1:0] er, input logic ee,
                       input int ec, input logic pc);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_p     = p;
    @(posedge clk);
    #1;
    e.r = er; e.err = ee; e.cyc_exp = ec; e.prod_chk = pc;
    e.mode = m; e.a = a; e.b = b; e.p = p; e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  // Monitor: compares each presented result against the oldest expectation.
  initial begin
    exp_t         e;
    logic         seen;
    int           lat;
    logic [W-1:0] want;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result out_r=%0h required=none", out_r);
          end else begin
            e   = exp_q.pop_front();
            lat = cyc - e.acc;
            chk("out_r", out_r, e.r);
            chk("out_err", W'(out_err), W'(e.err));
            chk("latency", W'(lat), W'(out_cycles));
            if (e.cyc_exp >= 0) chk("out_cycles", W'(out_cycles), W'(e.cyc_exp));
            else chk("cycles_bound", W'(out_cycles <= CW'(4 * W)), W'(1));
            if (e.prod_chk) begin
              want = e.mode ? e.b : W'(1);
              chk("r_times_a", modmul(out_r, e.a, e.p), want);
            end
          end
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, binv, hold_r;
    logic         m, hold_err;
    logic [CW-1:0] hold_cyc;
    int           n;

    P25519 = {W{1'b1}} >> 1;
    P25519 = P25519 - W'(18);

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_p = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_r", out_r, W'(0));
    chk("rst_out_err", W'(out_err), W'(0));
    chk("rst_out_cycles", W'(out_cycles), W'(0));
    chk("rst_busy", W'(busy), W'(0));

    // Small directed vectors (hand-stepped through the algorithm).
    issue(1'b0, W'(3), W'(0), W'(7), W'(5), 1'b0, 4, 1'b1);
    issue(1'b1, W'(3), W'(2), W'(7), W'(3), 1'b0, 4, 1'b1);
    issue(1'b1, W'(1), W'(6), W'(7), W'(6), 1'b0, 1, 1'b1);
    issue(1'b0, W'(3), W'(0), W'(9), W'(0), 1'b1, 4, 1'b0);
    // Rejected operands: even p, a = 0, a = p, b >= p in division mode.
    issue(1'b0, W'(3), W'(0), W'(8), W'(0), 1'b1, 0, 1'b0);
    issue(1'b0, W'(0), W'(0), W'(7), W'(0), 1'b1, 0, 1'b0);
    issue(1'b0, W'(7), W'(0), W'(7), W'(0), 1'b1, 0, 1'b0);
    issue(1'b1, W'(3), W'(7), W'(7), W'(0), 1'b1, 0, 1'b0);
    drain();

    // Large modulus: a = 2 inverts to (p+1)/2.
    issue(1'b0, W'(2), W'(0), P25519, (P25519 >> 1) + W'(1), 1'b0, -1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      a = rand256() % P25519;
      if (a == '0) a = W'(1);
      b = rand256() % P25519;
      m = 1'($urandom_range(0, 1));
      binv = modpow(a, P25519 - W'(2), P25519);
      issue(m, a, b, P25519, m ? modmul(b, binv, P25519) : binv, 1'b0, -1, 1'b1);
    end
    drain();

    // Consumer stall: results must hold while out_ready stays low.
    out_ready = 1'b0;
    issue(1'b0, W'(3), W'(0), W'(7), W'(5), 1'b0, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", W'(out_valid), W'(1));
    hold_r = out_r; hold_err = out_err; hold_cyc = out_cycles;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", W'(out_valid), W'(1));
      chk("stall_out_r", out_r, hold_r);
      chk("stall_out_err", W'(out_err), W'(hold_err));
      chk("stall_out_cycles", W'(out_cycles), W'(hold_cyc));
      chk("stall_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a long computation discards it.
    issue(1'b0, W'(5), W'(0), P25519, W'(0), 1'b0, -1, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrun_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    chk("post_rst_out_valid", W'(out_valid), W'(0));
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    chk("post_rst_busy", W'(busy), W'(0));
    issue(1'b0, W'(3), W'(0), W'(7), W'(5), 1'b0, 4, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
